// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_TIMEOUT_EN to add load-timeout recovery on the tx_err port.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                          txclk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_enable,
  output logic                          ld_tx_data,
  output logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_empty,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [15:0]                   frame_cnt,
  output logic                          tx_err
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e              state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [NUM_REQ-1:0]  req_ready_q;
  logic                tx_enable_q;
  logic                ld_tx_data_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic [PTR_W-1:0]    grant_id_q;
  logic                busy_q;
  logic [15:0]         frame_cnt_q;

  logic                found_d;
  logic [PTR_W-1:0]    sel_d;
  logic [PTR_W-1:0]    ptr_d;
  logic [NUM_REQ-1:0]  grant_vec_d;
  logic [DATA_W-1:0]   sel_data_d;

  function automatic logic [PTR_W-1:0] rr_idx(
    input logic [PTR_W-1:0] base,
    input int               off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Scan downward so the lowest offset from the pointer wins.
  always_comb begin
    found_d = 1'b0;
    sel_d   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_idx(ptr_q, k)]) begin
        found_d = 1'b1;
        sel_d   = rr_idx(ptr_q, k);
      end
    end
    ptr_d       = (sel_d == PTR_W'(NUM_REQ - 1)) ? '0 : sel_d + 1'b1;
    grant_vec_d = NUM_REQ'(1) << sel_d;
    sel_data_d  = req_data[int'(sel_d)*DATA_W +: DATA_W];
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] cnt_q;
  logic            tx_err_q;
`endif

  always_ff @(posedge txclk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      req_ready_q  <= '0;
      tx_enable_q  <= 1'b0;
      ld_tx_data_q <= 1'b0;
      tx_data_q    <= '0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      frame_cnt_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      tx_err_q     <= 1'b0;
`endif
    end else begin
      ld_tx_data_q <= 1'b0;
      req_ready_q  <= '0;
      tx_enable_q  <= 1'b1;
      busy_q       <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
      tx_err_q     <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (tx_empty && found_d) begin
            state_q      <= LOAD;
            tx_data_q    <= sel_data_d;
            grant_id_q   <= sel_d;
            ptr_q        <= ptr_d;
            ld_tx_data_q <= 1'b1;
            req_ready_q  <= grant_vec_d;
          end else begin
            busy_q      <= 1'b0;
            tx_enable_q <= |req_valid;
          end
        end
        LOAD: begin
          state_q <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (!tx_empty) begin
            state_q <= WAIT_DONE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            state_q     <= IDLE;
            tx_err_q    <= 1'b1;
            busy_q      <= 1'b0;
            tx_enable_q <= |req_valid;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
          if (tx_empty) begin
            state_q     <= IDLE;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            busy_q      <= 1'b0;
            tx_enable_q <= |req_valid;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign tx_enable  = tx_enable_q;
  assign ld_tx_data = ld_tx_data_q;
  assign tx_data    = tx_data_q;
  assign grant_id   = grant_id_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign tx_err     = tx_err_q;
`else
  assign tx_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter.
// Inputs change on negedge; outputs are observed on negedge.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic                       txclk = 1'b0;
  logic                       reset;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       tx_enable;
  logic                       ld_tx_data;
  logic [DATA_W-1:0]          tx_data;
  logic                       tx_empty;
  logic [1:0]                 grant_id;
  logic                       busy;
  logic [15:0]                frame_cnt;
  logic                       tx_err;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W(DATA_W),
    .TIMEOUT_CYC(16)
  ) dut (
    .txclk(txclk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_enable(tx_enable),
    .ld_tx_data(ld_tx_data),
    .tx_data(tx_data),
    .tx_empty(tx_empty),
    .grant_id(grant_id),
    .busy(busy),
    .frame_cnt(frame_cnt),
    .tx_err(tx_err)
  );

  always #5 txclk = ~txclk;

  task automatic tick(input int n);
    repeat (n) @(negedge txclk);
  endtask

  task automatic do_reset();
    @(negedge txclk);
    reset     = 1'b1;
    req_valid = '0;
    tx_empty  = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge txclk);
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_empty  = 1'b1;
    tick(2);
    checks++;
    if (req_ready !== 4'b0 || ld_tx_data !== 1'b0 || tx_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: ready=%b ld=%b en=%b want 0000/0/0",
               req_ready, ld_tx_data, tx_enable);
    end
    checks++;
    if (tx_data !== 8'h00 || grant_id !== 2'd0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: data=%h gid=%0d fc=%0d want 00/0/0",
               tx_data, grant_id, frame_cnt);
    end
    checks++;
    if (busy !== 1'b0 || tx_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: busy=%b err=%b want 0/0", busy, tx_err);
    end
    req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (req_ready !== 4'b0 || ld_tx_data !== 1'b0) begin
        errors++;
        $display("FAIL reset_held[%0d]: ready=%b ld=%b want 0000/0",
                 i, req_ready, ld_tx_data);
      end
    end
    req_valid = '0;
    reset     = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    do_reset();
    req_data[2*8 +: 8] = 8'h41;
    req_valid = 4'b0100;
    tx_empty  = 1'b1;
    tick(1);
    checks++;
    if (ld_tx_data !== 1'b1 || tx_data !== 8'h41 ||
        req_ready !== 4'b0100 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL single_load: ld=%b data=%h ready=%b gid=%0d want 1/41/0100/2",
               ld_tx_data, tx_data, req_ready, grant_id);
    end
    req_valid = '0;
    tx_empty  = 1'b0;
    tick(1);
    checks++;
    if (ld_tx_data !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_after: ld=%b ready=%b busy=%b want 0/0000/1",
               ld_tx_data, req_ready, busy);
    end
    tick(3);
    tx_empty = 1'b1;
    tick(1);
    checks++;
    if (frame_cnt !== 16'd1 || busy !== 1'b0 || tx_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_done: fc=%0d busy=%b en=%b want 1/0/0",
               frame_cnt, busy, tx_enable);
    end
    checks++;
    if (tx_data !== 8'h41 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL single_hold: data=%h gid=%0d want 41/2", tx_data, grant_id);
    end
  endtask

  task automatic test_all_requesters();
    logic [7:0] exp_b [4];
    int n;
    int stray;
    exp_b[0] = 8'h48; exp_b[1] = 8'h65;
    exp_b[2] = 8'h6C; exp_b[3] = 8'h6F;
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = exp_b[i];
    req_valid = 4'b1111;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (ld_tx_data !== 1'b1 && n < 10) begin
        tick(1);
        n++;
      end
      checks++;
      if (n >= 10 || tx_data !== exp_b[i] || grant_id !== 2'(i) ||
          req_ready !== 4'(1 << i)) begin
        errors++;
        $display("FAIL all_load[%0d]: data=%h gid=%0d ready=%b want %h/%0d/%b",
                 i, tx_data, grant_id, req_ready, exp_b[i], i, 4'(1 << i));
      end
      req_valid[i] = 1'b0;
      tx_empty     = 1'b0;
      for (int c = 0; c < 4; c++) begin
        tick(1);
        if (ld_tx_data !== 1'b0) stray++;
      end
      tx_empty = 1'b1;
    end
    tick(2);
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL all_stray_loads: got=%0d want 0", stray);
    end
    checks++;
    if (frame_cnt !== 16'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL all_count: fc=%0d busy=%b want 4/0", frame_cnt, busy);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g [4];
    int n;
    exp_g[0] = 2'd0; exp_g[1] = 2'd3;
    exp_g[2] = 2'd0; exp_g[3] = 2'd3;
    do_reset();
    req_data[0*8 +: 8] = 8'h10;
    req_data[3*8 +: 8] = 8'h13;
    req_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (ld_tx_data !== 1'b1 && n < 10) begin
        tick(1);
        n++;
      end
      checks++;
      if (n >= 10 || grant_id !== exp_g[i] ||
          tx_data !== (exp_g[i] == 2'd0 ? 8'h10 : 8'h13)) begin
        errors++;
        $display("FAIL fair_grant[%0d]: gid=%0d data=%h want %0d",
                 i, grant_id, tx_data, exp_g[i]);
      end
      tx_empty = 1'b0;
      tick(2);
      tx_empty = 1'b1;
    end
    req_valid = '0;
    tick(3);
  endtask

  task automatic test_busy_uart();
    do_reset();
    req_data[1*8 +: 8] = 8'h5A;
    req_valid = 4'b0010;
    tx_empty  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (ld_tx_data !== 1'b0 || busy !== 1'b0 || tx_enable !== 1'b1) begin
        errors++;
        $display("FAIL busy_hold[%0d]: ld=%b busy=%b en=%b want 0/0/1",
                 i, ld_tx_data, busy, tx_enable);
      end
    end
    tx_empty = 1'b1;
    tick(1);
    checks++;
    if (ld_tx_data !== 1'b1 || grant_id !== 2'd1 || tx_data !== 8'h5A) begin
      errors++;
      $display("FAIL busy_load: ld=%b gid=%0d data=%h want 1/1/5a",
               ld_tx_data, grant_id, tx_data);
    end
    req_valid = '0;
    tx_empty  = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'd0 || tx_enable !== 1'b0) begin
      errors++;
      $display("FAIL busy_midreset: busy=%b fc=%0d en=%b want 0/0/0",
               busy, frame_cnt, tx_enable);
    end
    reset    = 1'b0;
    tx_empty = 1'b1;
    tick(2);
  endtask

  task automatic test_timeout();
    int n;
    int pulses;
    int first;
    int busy_drop;
    do_reset();
    req_data[0*8 +: 8] = 8'h77;
    req_valid = 4'b0001;
    tx_empty  = 1'b1;
    n = 0;
    while (ld_tx_data !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= 10) begin
      errors++;
      $display("FAIL to_load: no load within %0d cycles", n);
    end
    req_valid = '0;
    pulses    = 0;
    first     = -1;
    busy_drop = 0;
    for (int c = 1; c <= 30; c++) begin
      tick(1);
      if (tx_err === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (busy !== 1'b1) busy_drop++;
    end
`ifdef UART_ARB_TIMEOUT_EN
    checks++;
    if (pulses != 1 || first != 17) begin
      errors++;
      $display("FAIL to_pulse: pulses=%0d at=%0d want 1 at 17", pulses, first);
    end
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL to_idle: busy=%b fc=%0d want 0/0", busy, frame_cnt);
    end
`else
    checks++;
    if (pulses != 0 || busy_drop != 0) begin
      errors++;
      $display("FAIL to_off: err_pulses=%0d busy_drops=%0d want 0/0",
               pulses, busy_drop);
    end
`endif
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_empty  = 1'b1;
    test_reset();
    test_single();
    test_all_requesters();
    test_fairness();
    test_busy_uart();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
